// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter for the switch fabric output resource.
// Bounded-hold grants with a rotating priority pointer.
module rr_port_arbiter #(
   parameter int unsigned N_PORTS  = 9,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned MAX_HOLD = 64,
   parameter int unsigned HOLD_W   = 7
) (
   input  logic               core_clock,
   input  logic               core_rst,
   input  logic [N_PORTS-1:0] req,
   input  logic [N_PORTS-1:0] port_en,
   output logic [N_PORTS-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid,
   output logic               timeout
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_e;

   state_e             state_q;
   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    id_q;
   logic [HOLD_W-1:0]  hold_q;
   logic [N_PORTS-1:0] gnt_q;
   logic               valid_q;
   logic               tmo_q;

   logic [N_PORTS-1:0] elig;
   logic               sel_vld;
   logic [ID_W-1:0]    sel_id;
   logic [ID_W-1:0]    idx_n;
   int                 idx;
   logic               expire;
   logic               keep;
   logic               last;

   assign elig   = req & port_en;
   assign expire = (hold_q == HOLD_W'(MAX_HOLD - 1));
   assign keep   = elig[id_q];
   assign last   = (id_q == ID_W'(N_PORTS - 1));

   // First eligible port at or after the pointer, wrapping once.
   always_comb begin
      sel_vld = 1'b0;
      sel_id  = '0;
      idx     = 0;
      idx_n   = '0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= int'(N_PORTS)) begin
            idx = idx - int'(N_PORTS);
         end
         idx_n = ID_W'(idx);
         if (!sel_vld && elig[idx_n]) begin
            sel_vld = 1'b1;
            sel_id  = idx_n;
         end
      end
   end

   always_ff @(posedge core_clock) begin
      if (core_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tmo_q <= 1'b0;
               if (sel_vld) begin
                  state_q <= GRANT;
                  gnt_q   <= N_PORTS'(1) << sel_id;
                  id_q    <= sel_id;
                  valid_q <= 1'b1;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (hold_q != '1) begin
                  hold_q <= hold_q + 1'b1;
               end
               // A release wins over a simultaneous expiry.
               if (!keep || expire) begin
                  state_q <= GAP;
                  gnt_q   <= '0;
                  valid_q <= 1'b0;
                  tmo_q   <= keep;
               end
            end
            GAP: begin
               tmo_q   <= 1'b0;
               ptr_q   <= last ? '0 : id_q + 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               valid_q <= 1'b0;
               tmo_q   <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = id_q;
   assign gnt_valid = valid_q;
   assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Randomized bench for rr_port_arbiter against a cycle-level
// round-robin reference built from port ownership and hold counts.
module tb_rr_port_arbiter;

   localparam int N   = 9;
   localparam int IDW = 4;
   localparam int MH  = 4;
   localparam int HW  = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   en;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;

   int total = 0;
   int bad   = 0;

   // Reference: current owner (-1 = none), cycles held, forced-idle
   // cycles left, rotation pointer, last owner, timeout expectation.
   int m_cur;
   int m_held;
   int m_gap;
   int m_ptr;
   int m_last;
   bit m_tmo;

   rr_port_arbiter #(
      .N_PORTS (N),
      .ID_W    (IDW),
      .MAX_HOLD(MH),
      .HOLD_W  (HW)
   ) dut (
      .core_clock(clk),
      .core_rst  (rst),
      .req       (req),
      .port_en   (en),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit bit_at(input logic [N-1:0] v, input int p);
      return ((v >> p) & N'(1)) != '0;
   endfunction

   task automatic model_step();
      logic [N-1:0] e;
      int p;
      e = req & en;
      if (rst) begin
         m_cur  = -1;
         m_held = 0;
         m_gap  = 0;
         m_ptr  = 0;
         m_last = 0;
         m_tmo  = 1'b0;
      end else if (m_cur >= 0) begin
         m_held++;
         m_tmo = 1'b0;
         if (!bit_at(e, m_cur) || m_held == MH) begin
            m_tmo = bit_at(e, m_cur);
            m_ptr = (m_cur + 1) % N;
            m_cur = -1;
            m_gap = 1;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         m_tmo = 1'b0;
      end else begin
         m_tmo = 1'b0;
         for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (m_cur < 0 && bit_at(e, p)) begin
               m_cur  = p;
               m_last = p;
               m_held = 0;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input logic [N-1:0] rq,
                        input logic [N-1:0] e_in);
      logic [N-1:0] exp_g;
      @(negedge clk);
      rst = r;
      req = rq;
      en  = e_in;
      @(posedge clk);
      model_step();
      #1;
      exp_g = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
      chk("gnt", 32'(gnt), 32'(exp_g));
      chk("gnt_id", 32'(gnt_id), 32'(m_last));
      chk("gnt_valid", 32'(gnt_valid), 32'(m_cur >= 0));
      chk("timeout", 32'(timeout), 32'(m_tmo));
   endtask

   logic [N-1:0] rq_r;
   logic [N-1:0] en_r;
   int           waited;

   initial begin
      rst = 1'b1;
      req = '0;
      en  = '0;
      cycle(1'b1, '0, '0);
      cycle(1'b1, 9'h1FF, 9'h1FF);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_id", 32'(gnt_id), 32'h0);

      // Single request, 1-cycle latency, expiry on a held request.
      cycle(1'b0, 9'h004, 9'h1FF);
      chk("t1_gnt", 32'(gnt), 32'h004);
      chk("t1_id", 32'(gnt_id), 32'd2);
      repeat (6) cycle(1'b0, 9'h004, 9'h1FF);
      repeat (3) cycle(1'b0, 9'h000, 9'h1FF);

      // Pointer now at 3: port 5 before port 0.
      repeat (10) cycle(1'b0, 9'h021, 9'h1FF);
      repeat (3) cycle(1'b0, 9'h000, 9'h1FF);

      // Full rotation with expiry.
      repeat (70) cycle(1'b0, 9'h1FF, 9'h1FF);
      repeat (3) cycle(1'b0, 9'h000, 9'h1FF);

      // Early release of port 7.
      repeat (2) cycle(1'b0, 9'h080, 9'h1FF);
      repeat (2) cycle(1'b0, 9'h080, 9'h1FF);
      repeat (3) cycle(1'b0, 9'h000, 9'h1FF);

      // Enable mask and enable withdrawn mid-grant.
      repeat (12) cycle(1'b0, 9'h003, 9'h1FE);
      repeat (2) cycle(1'b0, 9'h003, 9'h1FE);
      cycle(1'b0, 9'h003, 9'h1FC);
      repeat (3) cycle(1'b0, 9'h003, 9'h1FC);

      // Reset in the middle of a grant to port 4.
      waited = 0;
      while (m_cur != 4 && waited < 100) begin
         cycle(1'b0, 9'h1FF, 9'h1FF);
         waited++;
      end
      chk("t6_reach", 32'(m_cur == 4), 32'd1);
      cycle(1'b1, 9'h1FF, 9'h1FF);
      chk("t6_rst_gnt", 32'(gnt), 32'h0);
      cycle(1'b0, 9'h1FF, 9'h1FF);
      chk("t6_first", 32'(gnt), 32'h001);

      // Random traffic with occasional mask changes and resets.
      rq_r = '0;
      en_r = 9'h1FF;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) begin
               rq_r[b] = ~rq_r[b];
            end
         end
         if ($urandom_range(0, 15) == 0) begin
            en_r = ($urandom_range(0, 1) == 0) ? 9'h1FF : N'($urandom);
         end
         cycle($urandom_range(0, 299) == 0, rq_r, en_r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
